// File: rtl/imem_loader_m_if.sv
// imem_loader_m_if: control, byte-stream and instruction-memory write-port signals of the program loader.
// master = host/bench side, slave = loader side.
interface imem_loader_m_if #(
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  start;
    logic [15:0]           word_count;
    logic                  abort;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport master (
        output start, word_count, abort, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

    modport slave (
        input  start, word_count, abort, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader_m.sv
// imem_loader_m: byte-serial instruction-memory loader that stalls the CPU while a program streams in.
// Optional LOADER_CHECKSUM_EN: a trailing XOR checksum byte is verified before DONE.
module imem_loader_m #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned MAX_WORDS  = 256
) (
    input  logic           clock,
    input  logic           reset_n,
    imem_loader_m_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    // State entered once the last word (or an empty program) has been handled.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHECK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [23:0]           wbuf_q, wbuf_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  xfer;
    logic [31:0]           wc_ext;
    logic [CNT_W-1:0]      idx_inc;

    assign xfer    = bus.byte_valid && byte_ready_q;
    assign wc_ext  = 32'(bus.word_count);
    assign idx_inc = idx_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        idx_d        = idx_q;
        count_d      = count_q;
        wbuf_d       = wbuf_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        error_d      = error_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (wc_ext > MAX_WORDS) begin
                        error_d = 1'b1;
                    end else begin
                        error_d    = 1'b0;
                        byte_cnt_d = '0;
                        idx_d      = '0;
                        count_d    = CNT_W'(bus.word_count);
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = '0;
`endif
                        state_d    = (bus.word_count == 16'd0) ? S_TAIL : S_RECV;
                    end
                end
            end

            S_RECV: begin
                // abort wins over a completing word, so that word is never written
                if (bus.abort) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.byte_in;
`endif
                    case (byte_cnt_q)
                        2'd0:    wbuf_d[7:0]   = bus.byte_in;
                        2'd1:    wbuf_d[15:8]  = bus.byte_in;
                        2'd2:    wbuf_d[23:16] = bus.byte_in;
                        default: begin
                            imem_wdata_d = {bus.byte_in, wbuf_q};
                            imem_addr_d  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({idx_q, 2'b00});
                            state_d      = S_WRITE;
                        end
                    endcase
                end
            end

            S_WRITE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == count_q) ? S_TAIL : S_RECV;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else if (xfer) begin
                    if (bus.byte_in == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
`endif

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered by decoding the state being entered.
        byte_ready_d = (state_d == S_RECV);
        cpu_hold_d   = (state_d == S_RECV) || (state_d == S_WRITE);
`ifdef LOADER_CHECKSUM_EN
        byte_ready_d = byte_ready_d || (state_d == S_CHECK);
        cpu_hold_d   = cpu_hold_d || (state_d == S_CHECK);
`endif
        imem_we_d    = (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            wbuf_q       <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            wbuf_q       <= wbuf_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule

// File: doc/imem_loader_m.md
Name: imem_loader_m

Overview:
Byte-serial program loader that writes 32-bit instruction words into instruction memory, starting at BASE_ADDR. The PC unit and decoder only read instruction memory; this block is the writer side of that port. It holds the processor in stall (cpu_hold) while a program is loaded, then releases it. Bytes arrive over a valid/ready handshake from a host or bench, little-endian, four per word.

Parameters:
ADDR_WIDTH, 32, width of imem_addr (byte address, matches PC)
BASE_ADDR, 32'h0000_0000, byte address of the first word written
MAX_WORDS, 256, largest accepted word_count; also sets the counter width (clog2(MAX_WORDS)+1)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE
word_count  input  16  number of words to load; sampled with start
abort  input  1  cancel a load in progress
byte_in  input  8  incoming program byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  byte address of the word being written
imem_wdata  output  32  assembled instruction word
cpu_hold  output  1  stall the PC unit while loading
done  output  1  one-cycle pulse when a load completes successfully
error  output  1  sticky fault flag; cleared by the next accepted start

Behaviour:
- Reset (async, reset_n=0) sets state IDLE and drives all outputs to 0 (byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error). It discards any partial word and the word index. Reset mid-load means no further writes occur.
- All outputs are registered.
- A byte transfers on a rising edge where byte_valid=1 and byte_ready=1.
- States: IDLE, RECV, WRITE, CHECK (only with the optional feature), DONE.
- IDLE:
  - start=1 with 0 < word_count <= MAX_WORDS: clear error, clear byte and word counters, latch word_count, go to RECV.
  - start=1 with word_count > MAX_WORDS: set error, stay in IDLE.
  - start=1 with word_count = 0: go directly to DONE (or CHECK if enabled).
- RECV:
  - byte_ready=1 and cpu_hold=1.
  - Byte k of a word (k = 0..3) goes into wdata[8k+7:8k].
  - After the 4th byte is accepted, the next state is WRITE.
- WRITE (exactly 1 cycle):
  - imem_we=1, imem_addr = BASE_ADDR + 4*index, imem_wdata = assembled word, byte_ready=0.
  - index increments. If index now equals word_count, go to DONE (or CHECK); otherwise go to RECV.
- DONE (1 cycle): done=1, cpu_hold=0, byte_ready=0; then IDLE.
- Outside WRITE, imem_we=0. imem_addr and imem_wdata hold their last values.
- cpu_hold=1 in RECV, WRITE and CHECK, and 0 in IDLE and DONE. It rises the cycle after start is accepted.
- abort=1 in RECV, WRITE or CHECK:
  - Go to IDLE next cycle with error=1, cpu_hold=0, no done pulse.
  - abort has priority over a WRITE in the same cycle: that write is suppressed.
- start outside IDLE is ignored. abort in IDLE or DONE is ignored.
- Words already written before an abort or error stay in memory; no rollback.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: after the last word, the CHECK state sets byte_ready=1 and accepts one checksum byte. It compares that byte with the XOR of all 4*word_count program bytes (0x00 when word_count=0).
  - Match: DONE.
  - Mismatch: error=1, then IDLE with no done pulse.
- Not defined: CHECK does not exist, and the transition after the last WRITE (or after start with count 0) goes straight to DONE.

Test Plan:
- Reset, then start with word_count=2 and bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE with byte_valid held high.
  - imem_we pulses twice: addr 0x0 data 0x12345678, then addr 0x4 data 0xDEADBEEF.
  - done pulses once, the cycle after the second write.
  - cpu_hold is high from the cycle after start until done.
- Same load with byte_valid toggling 1,0,1,0: identical writes, with data unaffected by the gaps.
- start with word_count=300 (MAX_WORDS=256): error=1, state IDLE, cpu_hold stays 0, no writes. A following valid start clears error.
- abort asserted after 6 bytes of a 2-word load:
  - exactly one write (addr 0x0) occurs.
  - next cycle: error=1, cpu_hold=0, no done.
- reset_n pulsed low asynchronously mid-word: all outputs 0 immediately. A new load then writes its first word at BASE_ADDR.
- With LOADER_CHECKSUM_EN, 1-word load 0x01,0x02,0x04,0x08:
  - checksum byte 0x0F: done pulses.
  - checksum byte 0x0E: error=1, no done.
